// File: rtl/hack_pc_unit.sv
// Hack CPU program counter with jump decode and a small LIFO return-address stack.
// Optional HACK_PC_STACK_ERR_EN adds a sticky stack_err flag for dropped pushes and empty rets.
module hack_pc_unit #(
   parameter int WIDTH = 16,
   parameter int DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [WIDTH-1:0]         in,
   input  logic                     load,
   input  logic                     inc,
   input  logic [2:0]               jmp,
   input  logic                     zr,
   input  logic                     ng,
   input  logic                     call,
   input  logic                     ret,
   output logic [WIDTH-1:0]         out,
   output logic [$clog2(DEPTH):0]   depth,
   output logic                     empty,
`ifdef HACK_PC_STACK_ERR_EN
   output logic                     full,
   output logic                     stack_err
`else
   output logic                     full
`endif
);

   localparam int PW = $clog2(DEPTH);
   localparam logic [PW:0]      FULL_LVL = (PW+1)'(DEPTH);
   localparam logic [PW:0]      ONE_D    = (PW+1)'(1);
   localparam logic [PW-1:0]    ONE_P    = PW'(1);
   localparam logic [WIDTH-1:0] ONE_W    = WIDTH'(1);

   logic [WIDTH-1:0] stack [DEPTH];
   logic [WIDTH-1:0] ret_addr;
   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;
   logic             taken;
   logic             do_pop;
   logic             do_load;
   logic             do_push;
   logic             push_drop;

   // Pointer low bits wrap so that depth==DEPTH still reads the last slot.
   always_comb begin
      taken     = (jmp[2] & ng) | (jmp[1] & zr) | (jmp[0] & ~ng & ~zr);
      do_pop    = ret & ~empty;
      do_load   = ~do_pop & (load | taken);
      do_push   = do_load & call & ~full;
      push_drop = do_load & call & full;
      ret_addr  = out + ONE_W;
      wr_ptr    = depth[PW-1:0];
      rd_ptr    = depth[PW-1:0] - ONE_P;
   end

   assign empty = (depth == '0);
   assign full  = (depth == FULL_LVL);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out   <= '0;
         depth <= '0;
      end else if (do_pop) begin
         out   <= stack[rd_ptr];
         depth <= depth - ONE_D;
      end else if (do_load) begin
         out <= in;
         if (do_push)
            depth <= depth + ONE_D;
      end else if (inc) begin
         out <= ret_addr;
      end
   end

   // Stack contents need no reset; depth alone decides which entries are valid.
   always_ff @(posedge clk) begin
      if (do_push)
         stack[wr_ptr] <= ret_addr;
   end

`ifdef HACK_PC_STACK_ERR_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         stack_err <= 1'b0;
      else if (push_drop | (ret & empty))
         stack_err <= 1'b1;
   end
`else
   logic unused_drop;
   assign unused_drop = push_drop;
`endif

endmodule

// File: tb/tb_hack_pc_unit.sv
// Self-checking bench for hack_pc_unit: queue-based reference model, directed plan, random traffic.
module tb_hack_pc_unit;

   localparam int WIDTH = 16;
   localparam int DEPTH = 8;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [15:0] in = '0;
   logic        load = 1'b0;
   logic        inc = 1'b0;
   logic [2:0]  jmp = '0;
   logic        zr = 1'b0;
   logic        ng = 1'b0;
   logic        call = 1'b0;
   logic        ret = 1'b0;
   logic [15:0] out;
   logic [3:0]  depth;
   logic        empty;
   logic        full;
   logic        stack_err;

   int n_cmp = 0;
   int n_fail = 0;
   bit check_en = 1'b0;

   int pc_m = 0;
   int stk_m[$];
   bit err_m = 1'b0;
   bit tk_m;
   int ret_w = 1;

   always #5 clk = ~clk;

   hack_pc_unit #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
      .clk(clk),
      .rst_n(rst_n),
      .in(in),
      .load(load),
      .inc(inc),
      .jmp(jmp),
      .zr(zr),
      .ng(ng),
      .call(call),
      .ret(ret),
      .out(out),
      .depth(depth),
      .empty(empty),
`ifdef HACK_PC_STACK_ERR_EN
      .full(full),
      .stack_err(stack_err)
`else
      .full(full)
`endif
   );

`ifndef HACK_PC_STACK_ERR_EN
   assign stack_err = 1'b0;
`endif

   task automatic checkOutput(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_fail++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: a plain integer PC and a queue used as the return stack.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_m = 0;
         stk_m.delete();
         err_m = 1'b0;
      end else begin
         tk_m = (jmp[2] && ng) || (jmp[1] && zr) || (jmp[0] && !ng && !zr);
         if (ret && stk_m.size() > 0) begin
            pc_m = stk_m.pop_back();
         end else begin
            if (ret)
               err_m = 1'b1;
            if (load || tk_m) begin
               if (call) begin
                  if (stk_m.size() < DEPTH)
                     stk_m.push_back((pc_m + 1) % 65536);
                  else
                     err_m = 1'b1;
               end
               pc_m = int'(in);
            end else if (inc) begin
               pc_m = (pc_m + 1) % 65536;
            end
         end
      end
   end

   always @(negedge clk) begin
      if (check_en) begin
         checkOutput("cmp_out", int'(out), pc_m);
         checkOutput("cmp_depth", int'(depth), stk_m.size());
         checkOutput("cmp_empty", int'(empty), int'(stk_m.size() == 0));
         checkOutput("cmp_full", int'(full), int'(stk_m.size() == DEPTH));
`ifdef HACK_PC_STACK_ERR_EN
         checkOutput("cmp_stack_err", int'(stack_err), int'(err_m));
`endif
      end
   end

   task automatic applyStimulus(input logic [15:0] a_in, input logic a_load, input logic a_inc,
                                input logic [2:0] a_jmp, input logic a_zr, input logic a_ng,
                                input logic a_call, input logic a_ret);
      @(negedge clk);
      in = a_in; load = a_load; inc = a_inc; jmp = a_jmp;
      zr = a_zr; ng = a_ng; call = a_call; ret = a_ret;
      @(posedge clk);
      #1;
   endtask

   task automatic doReset();
      @(negedge clk);
      in = '0; load = 0; inc = 0; jmp = '0; zr = 0; ng = 0; call = 0; ret = 0;
      #2 rst_n = 1'b0;
      #1;
      checkOutput("rst_out", int'(out), 0);
      checkOutput("rst_depth", int'(depth), 0);
      checkOutput("rst_empty", int'(empty), 1);
      checkOutput("rst_full", int'(full), 0);
`ifdef HACK_PC_STACK_ERR_EN
      checkOutput("rst_stack_err", int'(stack_err), 0);
`endif
      @(negedge clk);
      #2 rst_n = 1'b1;
   endtask

   initial begin
      check_en = 1'b1;
      doReset();

      // Reset and increment
      for (int i = 1; i <= 5; i++) begin
         applyStimulus(16'h0, 0, 1, 3'b000, 0, 0, 0, 0);
         checkOutput("inc_seq", int'(out), i);
      end
      applyStimulus(16'h0, 0, 0, 3'b000, 0, 0, 0, 0);
      checkOutput("hold", int'(out), 5);
      applyStimulus(16'hFFFF, 1, 0, 3'b000, 0, 0, 0, 0);
      checkOutput("load_ffff", int'(out), 16'hFFFF);
      applyStimulus(16'h0, 0, 1, 3'b000, 0, 0, 0, 0);
      checkOutput("inc_wrap", int'(out), 0);

      // Jump decode: (zr,ng) pairs select which jmp bit must be set
      for (int fp = 0; fp < 3; fp++) begin
         logic fzr, fng;
         int   cls;
         fzr = (fp == 0);
         fng = (fp == 1);
         cls = (fp == 0) ? 1 : ((fp == 1) ? 2 : 0);
         for (int j = 0; j < 8; j++) begin
            applyStimulus(16'h0010, 1, 0, 3'b000, 0, 0, 0, 0);
            applyStimulus(16'h0040, 0, 1, 3'(j), fzr, fng, 0, 0);
            checkOutput("jump_decode", int'(out), (((j >> cls) & 1) != 0) ? 16'h0040 : 16'h0011);
         end
      end

      // Call/ret round trip
      applyStimulus(16'h0010, 1, 0, 3'b000, 0, 0, 0, 0);
      applyStimulus(16'h0100, 0, 0, 3'b111, 0, 0, 1, 0);
      checkOutput("call_out", int'(out), 16'h0100);
      checkOutput("call_depth", int'(depth), 1);
      applyStimulus(16'h0, 0, 1, 3'b000, 0, 0, 0, 0);
      applyStimulus(16'h0, 0, 1, 3'b000, 0, 0, 0, 0);
      checkOutput("call_inc2", int'(out), 16'h0102);
      checkOutput("model_inc2", pc_m, 16'h0102);
      applyStimulus(16'h0, 0, 0, 3'b000, 0, 0, 0, 1);
      checkOutput("ret_out", int'(out), 16'h0011);
      checkOutput("ret_depth", int'(depth), 0);
      checkOutput("ret_empty", int'(empty), 1);
      checkOutput("model_ret", pc_m, 16'h0011);

      // Stack full: nine taken calls, the last push is dropped
      applyStimulus(16'h0020, 1, 0, 3'b000, 0, 0, 0, 0);
      for (int k = 0; k < 9; k++) begin
         applyStimulus(16'(16'h1000 + 16 * k), 0, 0, 3'b111, 0, 0, 1, 0);
         checkOutput("fill_depth", int'(depth), (k < 8) ? k + 1 : 8);
      end
      checkOutput("fill_full", int'(full), 1);
      checkOutput("fill_out", int'(out), 16'h1080);
`ifdef HACK_PC_STACK_ERR_EN
      checkOutput("fill_stack_err", int'(stack_err), 1);
`endif
      for (int i = 0; i < 8; i++) begin
         applyStimulus(16'h0, 0, 0, 3'b000, 0, 0, 0, 1);
         checkOutput("unwind_out", int'(out), (i < 7) ? (16'h1061 - 16 * i) : 16'h0021);
      end
      checkOutput("unwind_empty", int'(empty), 1);

      // Empty ret falls through to load; ret wins over call+load
      doReset();
      applyStimulus(16'h0200, 1, 0, 3'b000, 0, 0, 0, 1);
      checkOutput("eret_out", int'(out), 16'h0200);
      checkOutput("eret_depth", int'(depth), 0);
`ifdef HACK_PC_STACK_ERR_EN
      checkOutput("eret_stack_err", int'(stack_err), 1);
`endif
      applyStimulus(16'h0300, 1, 0, 3'b000, 0, 0, 1, 0);
      applyStimulus(16'h0400, 1, 0, 3'b000, 0, 0, 1, 0);
      checkOutput("two_depth", int'(depth), 2);
      applyStimulus(16'h0500, 1, 0, 3'b111, 0, 0, 1, 1);
      checkOutput("popwins_out", int'(out), 16'h0301);
      checkOutput("popwins_depth", int'(depth), 1);

      // Reset mid-operation with entries on the stack
      applyStimulus(16'h0600, 1, 0, 3'b000, 0, 0, 1, 0);
      applyStimulus(16'h0700, 1, 0, 3'b000, 0, 0, 1, 0);
      checkOutput("three_depth", int'(depth), 3);
      doReset();
      applyStimulus(16'h0, 0, 0, 3'b000, 0, 0, 0, 1);
      checkOutput("postrst_ret_out", int'(out), 0);
      checkOutput("postrst_ret_depth", int'(depth), 0);

      // Random traffic, ret pressure alternating to reach both full and empty
      for (int c = 0; c < 4000; c++) begin
         @(negedge clk);
         ret_w = ((c / 250) % 2 == 0) ? 1 : 5;
         in   = 16'($urandom);
         load = ($urandom_range(0, 5) == 0);
         inc  = 1'($urandom_range(0, 1));
         jmp  = 3'($urandom_range(0, 7));
         zr   = ($urandom_range(0, 2) == 0);
         ng   = ($urandom_range(0, 2) == 0);
         call = ($urandom_range(0, 2) != 0);
         ret  = ($urandom_range(0, 9) < ret_w);
         if ($urandom_range(0, 299) == 0) begin
            #2 rst_n = 1'b0;
            #1 rst_n = 1'b1;
         end
      end
      @(negedge clk);
      in = '0; load = 0; inc = 0; jmp = '0; call = 0; ret = 0;
      @(negedge clk);
      check_en = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
